// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers.
// Define MUL_DIV_UNIT_FAST_MUL_EN for a single-cycle combinational multiply.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;
   logic [WIDTH-1:0]   mag_a_q, mag_a_d;
   logic [WIDTH-1:0]   mag_b_q, mag_b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               sgn_op;
   logic [WIDTH-1:0]   mag_a_in;
   logic [WIDTH-1:0]   mag_b_in;
   logic [WIDTH:0]     div_top;
   logic               div_ge;
   logic [WIDTH:0]     div_rem;
   logic [2*WIDTH-1:0] div_step;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   // Magnitudes are unsigned, so the most negative value maps to 2^(WIDTH-1).
   assign sgn_op   = ~op[0];
   assign mag_a_in = (sgn_op & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
   assign mag_b_in = (sgn_op & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

   // Restoring division on {remainder, quotient}; dividend shifts in from the bottom.
   assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_ge   = div_top >= {1'b0, mag_b_q};
   assign div_rem  = div_ge ? (div_top - {1'b0, mag_b_q}) : div_top;
   assign div_step = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};

   assign prod = (sa_q ^ sb_q) ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
   assign quo  = (sa_q ^ sb_q) ? (~acc_q[WIDTH-1:0] + WIDTH'(1))
                               : acc_q[WIDTH-1:0];
   assign rem  = sa_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1))
                      : acc_q[2*WIDTH-1:WIDTH];

`ifdef MUL_DIV_UNIT_FAST_MUL_EN
   logic [2*WIDTH-1:0] mul_full;
   assign mul_full = {{WIDTH{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, mag_b_q};
`else
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? mag_a_q : {WIDTH{1'b0}})};
   assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      a_raw_d  = a_raw_q;
      mag_a_d  = mag_a_q;
      mag_b_d  = mag_b_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  3'd0, 3'd1, 3'd2, 3'd3: begin
                     state_d  = S_RUN;
                     cnt_d    = '0;
                     is_div_d = op[1];
                     sa_d     = sgn_op & a[WIDTH-1];
                     sb_d     = sgn_op & b[WIDTH-1];
                     a_raw_d  = a;
                     mag_a_d  = mag_a_in;
                     mag_b_d  = mag_b_in;
                     acc_d    = op[1] ? {{WIDTH{1'b0}}, mag_a_in}
                                      : {{WIDTH{1'b0}}, mag_b_in};
                  end
                  3'd4: begin
                     hi_d   = a;
                     done_d = 1'b1;
                  end
                  3'd5: begin
                     lo_d   = a;
                     done_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (is_div_q) begin
               acc_d = div_step;
               if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end else begin
`ifdef MUL_DIV_UNIT_FAST_MUL_EN
               acc_d   = mul_full;
               state_d = S_FIX;
`else
               acc_d = mul_step;
               if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
`endif
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (!is_div_q) begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end else if (mag_b_q == '0) begin
               hi_d = a_raw_q;
               lo_d = {WIDTH{1'b1}};
            end else begin
               hi_d = rem;
               lo_d = quo;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         a_raw_q  <= '0;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         a_raw_q  <= a_raw_d;
         mag_a_q  <= mag_a_d;
         mag_b_q  <= mag_b_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: results, latency, handshake, reset.
module tb_mul_div_unit;

   localparam int W = 32;
`ifdef MUL_DIV_UNIT_FAST_MUL_EN
   localparam int LAT_MUL = 3;
`else
   localparam int LAT_MUL = W + 2;
`endif
   localparam int LAT_DIV = W + 2;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op_r = 3'd0;
   logic [W-1:0] a_r = '0;
   logic [W-1:0] b_r = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int vectors = 0;
   int miscompares = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op_r),
      .a(a_r), .b(b_r), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1; op_r = o; a_r = x; b_r = y;
      @(negedge clk);
      start = 1'b0; op_r = 3'd1;
      a_r = 32'hA5A5_A5A5; b_r = 32'h5A5A_5A5A;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
         miscompares++;
         $display("FAIL reset got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                  busy, done, hi, lo);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_mul(input string nm, input logic [2:0] o,
                           input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
      int lat;
      issue(o, x, y);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_busy got %b want 1", nm, busy);
      end
      wait_done(lat);
      vectors++;
      if (lat !== LAT_MUL) begin
         miscompares++;
         $display("FAIL %s_latency got %0d want %0d", nm, lat, LAT_MUL);
      end
      vectors++;
      if (hi !== eh || lo !== el || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0",
                  nm, hi, lo, busy, eh, el);
      end
   endtask

   task automatic test_div(input string nm, input logic [2:0] o,
                           input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
      int lat;
      issue(o, x, y);
      wait_done(lat);
      vectors++;
      if (lat !== LAT_DIV) begin
         miscompares++;
         $display("FAIL %s_latency got %0d want %0d", nm, lat, LAT_DIV);
      end
      vectors++;
      if (hi !== eh || lo !== el) begin
         miscompares++;
         $display("FAIL %s got hi=%h lo=%h want hi=%h lo=%h",
                  nm, hi, lo, eh, el);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int extra;
      issue(3'd1, 32'h0001_0000, 32'h0001_0003);
      lat = 1;
      while (!done && lat < 100) begin
         start = (lat == 2);
         if (lat == 2) begin
            op_r = 3'd3; a_r = 32'd100; b_r = 32'd3;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      vectors++;
      if (lat !== LAT_MUL || hi !== 32'h1 || lo !== 32'h0003_0000) begin
         miscompares++;
         $display("FAIL ignore_mid got lat=%0d hi=%h lo=%h want lat=%0d hi=1 lo=00030000",
                  lat, hi, lo, LAT_MUL);
      end
      start = 1'b1; op_r = 3'd3; a_r = 32'd100; b_r = 32'd3;
      @(negedge clk);
      start = 1'b0; a_r = '0; b_r = '0;
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done);
      end
      wait_done(lat);
      vectors++;
      if (lat !== LAT_DIV || hi !== 32'd1 || lo !== 32'd33) begin
         miscompares++;
         $display("FAIL b2b_divu got lat=%0d hi=%h lo=%h want lat=%0d hi=1 lo=21",
                  lat, hi, lo, LAT_DIV);
      end
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      vectors++;
      if (extra !== 0) begin
         miscompares++;
         $display("FAIL no_queue got %0d busy/done cycles want 0", extra);
      end
   endtask

   task automatic test_mthi_mtlo();
      int lat;
      issue(3'd4, 32'h1234_5678, 32'h0);
      wait_done(lat);
      vectors++;
      if (lat !== 1 || busy !== 1'b0 || hi !== 32'h1234_5678
          || lo !== 32'd33) begin
         miscompares++;
         $display("FAIL mthi got lat=%0d busy=%b hi=%h lo=%h want 1 0 12345678 00000021",
                  lat, busy, hi, lo);
      end
      issue(3'd5, 32'h9ABC_DEF0, 32'h0);
      wait_done(lat);
      vectors++;
      if (lat !== 1 || busy !== 1'b0 || hi !== 32'h1234_5678
          || lo !== 32'h9ABC_DEF0) begin
         miscompares++;
         $display("FAIL mtlo got lat=%0d busy=%b hi=%h lo=%h want 1 0 12345678 9abcdef0",
                  lat, busy, hi, lo);
      end
   endtask

   task automatic test_reserved();
      int act;
      act = 0;
      issue(3'd6, 32'hFFFF_FFFF, 32'h1);
      repeat (10) begin
         if (busy || done) act++;
         @(negedge clk);
      end
      vectors++;
      if (act !== 0 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
         miscompares++;
         $display("FAIL reserved got act=%0d hi=%h lo=%h want 0 12345678 9abcdef0",
                  act, hi, lo);
      end
   endtask

   task automatic test_reset_abort();
      int seen;
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
         miscompares++;
         $display("FAIL reset_abort got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                  busy, done, hi, lo);
      end
      reset_n = 1'b1;
      seen = 0;
      repeat (50) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      vectors++;
      if (seen !== 0 || hi !== '0 || lo !== '0) begin
         miscompares++;
         $display("FAIL abort_no_done got %0d active cycles hi=%h lo=%h want 0",
                  seen, hi, lo);
      end
   endtask

   initial begin
      test_reset();
      test_mul("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001);
      test_mul("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1);
      test_mul("mult_minsq", 3'd0, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000);
      test_div("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
      test_div("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000);
      test_div("divu_zero", 3'd3, 32'd7, 32'd0,
               32'd7, 32'hFFFF_FFFF);
      test_div("div_zero", 3'd2, 32'hFFFF_FFF0, 32'd0,
               32'hFFFF_FFF0, 32'hFFFF_FFFF);
      test_back_to_back();
      test_mthi_mtlo();
      test_reserved();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised, multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the combinational ALU in the EX stage of the pipelined MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO under a start/busy/done handshake. HI/LO hold their values between operations. The pipeline stalls any MFHI/MFLO issue while `busy` is high.

## Interface
- `WIDTH`, 32, operand and HI/LO width; ≥ 4, even.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved.
- `a` in WIDTH: multiplicand / dividend / MTHI-MTLO source.
- `b` in WIDTH: multiplier / divisor.
- `busy` out 1: operation in flight; new `start` is ignored.
- `done` out 1: one-cycle pulse; HI/LO hold the new result in the same cycle.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: iterates, one bit per cycle, WIDTH cycles.
  - FIX: applies sign correction, writes HI/LO, pulses `done`, returns to IDLE.
- On the start edge (IDLE, `start`=1):
  - Latches `op`, `a`, `b`, and operand signs for the signed ops.
  - Converts signed operands to magnitudes; magnitudes are treated as unsigned, so the most negative value maps to 2^(WIDTH-1).
  - Clears the iteration counter.
- MULT/MULTU: shift-add over a 2·WIDTH accumulator. Product negated in FIX when sign(a) ≠ sign(b), signed ops only. {hi,lo} = full 2·WIDTH product.
- DIV/DIVU: restoring division. In FIX:
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
  - lo = quotient, hi = remainder.
- DIV of (most-negative ÷ −1): lo = most-negative, hi = 0. No trap.
- Divide by zero (DIV or DIVU): lo = all ones, hi = `a` exactly as given. No sign fix. Full latency still applies.
- MTHI/MTLO: never leave IDLE. The start edge writes `a` into hi or lo, the other register is unchanged, and `done` pulses the next cycle. `busy` stays 0.
- Reserved op: request ignored; no `busy`, no `done`, HI/LO unchanged.
- `start` while `busy`=1: ignored, no queuing. Operands may change freely after the start edge.

## Timing
- Reset (`reset_n`=0 at an edge): state = IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - Reset takes priority over every other event, including an in-flight operation, which is discarded with no `done`.
- Multiply/divide, start edge at edge k:
  - `busy`=1 after edges k+1 … k+WIDTH+1 (RUN then FIX).
  - After edge k+WIDTH+2: `done`=1, `busy`=0, hi/lo valid.
  - Total latency: WIDTH+2 cycles (34 at WIDTH=32).
- A new `start` may be accepted in the cycle `done` is high (back-to-back). Its start edge is k+WIDTH+2.
- `done` is registered, exactly one cycle, and never asserted together with `busy`.
- HI/LO change only at the edge that raises `done`, or at reset.

## Configuration
- `MUL_DIV_UNIT_FAST_MUL_EN` defined:
  - MULT/MULTU compute the full product in a single RUN cycle using a combinational multiplier.
  - Latency is 3 cycles: `done` after edge k+3.
  - Divide path unchanged.
- Undefined: iterative shift-add multiplier, latency WIDTH+2.
- Either way, results are bit-identical.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. `done` 34 cycles after start, or 3 with the fast macro.
- MULT a=−3, b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 ÷ −1 → lo=0x80000000, hi=0. DIVU 7 ÷ 0 → hi=7, lo=0xFFFFFFFF.
- Second `start` (DIVU 100/3) issued mid-MULT → ignored: only one `done`, with the MULT result. Then back-to-back start in the `done` cycle → accepted, lo=33, hi=1.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 → hi/lo updated one cycle after each, `busy` never high. Reserved op 6 → no `done`, HI/LO unchanged.
- `reset_n` pulled low at cycle 10 of a DIV → next cycle `busy`=0, `done`=0, hi=lo=0. No `done` ever appears for the aborted op.
